// File: rtl/clock_ratio_monitor.sv
// Clock ratio monitor: measures a divided clock in source-clock cycles.
// Ports: clk/resetb, enable, sense, N in; period, high_time, meas_valid, match, locked, stuck out.
module clock_ratio_monitor #(
  parameter int SIZE  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enable,
  input  logic             sense,
  input  logic [SIZE-1:0]  N,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             match,
  output logic             locked,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, hcnt_q;
  logic [1:0]       lock_q;

  logic             rise;
  logic [CNT_W-1:0] nv, half;
  logic             hit;
  logic [1:0]       lock_d;

  assign rise = s2_q & ~s3_q;

  // Compare the running counters against N; used at the rise.
  always_comb begin
    nv = '0;
    nv[SIZE-1:0] = N;
    half = nv >> 1;
    hit = 1'b0;
    if (nv[CNT_W-1:1] != '0) begin
      if (!nv[0])
        hit = (cnt_q == nv) && (hcnt_q == half);
      else
        hit = (cnt_q == nv) &&
              ((hcnt_q == half) || (hcnt_q == half + 1'b1));
    end
  end

  // Lock count saturates at 2 so locked holds while matches continue.
  always_comb begin
    lock_d = 2'd0;
    if (hit)
      lock_d = (lock_q == 2'd2) ? 2'd2 : lock_q + 2'd1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      lock_q     <= 2'd0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      match      <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      s1_q       <= sense;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      meas_valid <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        lock_q  <= 2'd0;
        match   <= 1'b0;
        locked  <= 1'b0;
        stuck   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (rise) begin
              cnt_q   <= 1;
              hcnt_q  <= 1;
              state_q <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              period     <= cnt_q;
              high_time  <= hcnt_q;
              meas_valid <= 1'b1;
              match      <= hit;
              lock_q     <= lock_d;
              locked     <= (lock_d == 2'd2);
              cnt_q      <= 1;
              hcnt_q     <= 1;
            end else if (cnt_q == CMAX) begin
              // No edge for a full counter span: divider presumed dead.
              stuck   <= 1'b1;
              locked  <= 1'b0;
              match   <= 1'b0;
              lock_q  <= 2'd0;
              state_q <= ARM;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              // s2 stays low from the fall until the next rise.
              if (s2_q && hcnt_q != CMAX)
                hcnt_q <= hcnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
